// File: rtl/sdram_host_bridge.sv
// Host valid/ready front-end for async_sdram_ctrl: packs 41-bit commands, tracks reads, returns data in order.
// Optional read-response watchdog is compiled in by defining SDRAM_BRIDGE_TIMEOUT_EN.
module sdram_host_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        host_req_i,
    input  logic        host_we_i,
    input  logic [23:0] host_addr_i,
    input  logic [15:0] host_wdata_i,
    output logic        host_ready_o,
    output logic        host_rvalid_o,
    output logic [15:0] host_rdata_o,
    output logic [40:0] cmd_d_o,
    output logic        cmd_enq_o,
    input  logic        cmd_full_i,
    input  logic [15:0] rsp_q_i,
    output logic        rsp_deq_o,
    input  logic        rsp_empty_i,
    output logic        busy_o,
    output logic        error_o
);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("sdram_host_bridge: MAX_OUTSTANDING must be 1..15 and TIMEOUT_CYCLES >= 1");
    end

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    logic [3:0] inflight;
    logic       accept;
    logic       rd_accept;
    logic       deq_d1;

    // Ready is held low while a command is being enqueued so the writer full flag has a cycle to update.
    assign host_ready_o = !reset_i && !cmd_full_i && !cmd_enq_o
                          && (host_we_i || (inflight < MAX_OUT));
    assign accept       = host_req_i && host_ready_o;
    assign rd_accept    = accept && !host_we_i;
    assign busy_o       = (inflight != 4'd0) || cmd_enq_o || deq_d1 || host_rvalid_o;

    // NOTE: every register below uses non-blocking assignment so all of them sample pre-edge values;
    // a blocking write here would let later statements see the new value and silently shift timing.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            cmd_d_o       <= '0;
            cmd_enq_o     <= 1'b0;
            inflight      <= 4'd0;
            rsp_deq_o     <= 1'b0;
            deq_d1        <= 1'b0;
            host_rvalid_o <= 1'b0;
            host_rdata_o  <= '0;
        end else begin
            cmd_enq_o <= accept;
            if (accept) begin
                cmd_d_o <= host_we_i ? {1'b1, host_addr_i, host_wdata_i}
                                     : {1'b0, host_addr_i, 16'h0000};
            end

            case ({rd_accept, rsp_deq_o})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase

            // Only pop what was asked for; the gap cycle lets inflight settle before the next pop.
            rsp_deq_o <= !rsp_empty_i && (inflight != 4'd0) && !rsp_deq_o;

            // Reader FIFO presents popped data one cycle after the dequeue strobe.
            deq_d1        <= rsp_deq_o;
            host_rvalid_o <= deq_d1;
            if (deq_d1) begin
                host_rdata_o <= rsp_q_i;
            end
        end
    end

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    localparam int unsigned    WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    // Counter saturates at its last value; the error flag stays set until reset.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else if (inflight == 4'd0 || rsp_deq_o) begin
            wd_cnt <= '0;
        end else if (wd_cnt == WD_LAST) begin
            err_q <= 1'b1;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_host_bridge.sv
// Directed bench for sdram_host_bridge with a small reader-FIFO model (data appears one cycle after pop).
module tb_sdram_host_bridge;

    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned TMO     = 16;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        host_req_i = 1'b0;
    logic        host_we_i = 1'b0;
    logic [23:0] host_addr_i = '0;
    logic [15:0] host_wdata_i = '0;
    logic        host_ready_o;
    logic        host_rvalid_o;
    logic [15:0] host_rdata_o;
    logic [40:0] cmd_d_o;
    logic        cmd_enq_o;
    logic        cmd_full_i = 1'b0;
    logic [15:0] rsp_q_i = 16'h0BAD;
    logic        rsp_deq_o;
    logic        rsp_empty_i;
    logic        busy_o;
    logic        error_o;

    sdram_host_bridge #(.MAX_OUTSTANDING(MAX_OUT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_i(reset_i),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
        .host_wdata_i(host_wdata_i), .host_ready_o(host_ready_o), .host_rvalid_o(host_rvalid_o),
        .host_rdata_o(host_rdata_o), .cmd_d_o(cmd_d_o), .cmd_enq_o(cmd_enq_o),
        .cmd_full_i(cmd_full_i), .rsp_q_i(rsp_q_i), .rsp_deq_o(rsp_deq_o),
        .rsp_empty_i(rsp_empty_i), .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reader FIFO model: pop on rsp_deq_o, word valid in the following cycle, junk otherwise.
    logic [15:0] rsp_mem [0:63];
    int rsp_wr = 0;
    int rsp_rd = 0;
    assign rsp_empty_i = (rsp_wr == rsp_rd);

    always @(posedge clk) begin
        if (reset_i) begin
            rsp_rd <= rsp_wr;
        end else if (rsp_deq_o) begin
            rsp_q_i <= rsp_mem[rsp_rd[5:0]];
            rsp_rd  <= rsp_rd + 1;
        end else begin
            rsp_q_i <= 16'h0BAD;
        end
    end

    task automatic inject(input logic [15:0] w);
        rsp_mem[rsp_wr[5:0]] = w;
        rsp_wr = rsp_wr + 1;
    endtask

    // Host-side monitor.
    logic [15:0] rx_mem [0:63];
    int   rx_cnt  = 0;
    int   enq_cnt = 0;
    int   deq_cnt = 0;
    int   b2b_cnt = 0;
    logic deq_prev = 1'b0;

    always @(negedge clk) begin
        if (host_rvalid_o) begin
            rx_mem[rx_cnt[5:0]] <= host_rdata_o;
            rx_cnt <= rx_cnt + 1;
        end
        if (cmd_enq_o) enq_cnt <= enq_cnt + 1;
        if (rsp_deq_o) deq_cnt <= deq_cnt + 1;
        if (rsp_deq_o && deq_prev) b2b_cnt <= b2b_cnt + 1;
        deq_prev <= rsp_deq_o;
    end

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request and hold it until accepted (bounded); returns just after the accept edge.
    task automatic issue(input logic we, input logic [23:0] a, input logic [15:0] d, output bit ok);
        int n = 0;
        host_req_i = 1'b1; host_we_i = we; host_addr_i = a; host_wdata_i = d;
        #1;
        while (!host_ready_o && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        ok = host_ready_o;
        @(posedge clk);
        #1;
        host_req_i = 1'b0;
    endtask

    // Expect a dequeue pulse, then rvalid exactly two cycles later carrying exp.
    task automatic wait_rsp(input string name, input logic [15:0] exp);
        int n = 0;
        @(negedge clk);
        while (!rsp_deq_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, " deq pulse"}, rsp_deq_o, 1);
        @(negedge clk);
        check({name, " rvalid D+1"}, host_rvalid_o, 0);
        @(negedge clk);
        check({name, " rvalid D+2"}, host_rvalid_o, 1);
        check({name, " rdata"}, host_rdata_o, exp);
        @(negedge clk);
        check({name, " rvalid D+3"}, host_rvalid_o, 0);
        check({name, " rdata hold"}, host_rdata_o, exp);
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [15:0] rsp;
        logic [40:0] exp_cmd;
    } vec_t;

    vec_t vecs [7];
    bit   ok;
    int   base, d0, r0, e0, rdy_hi, n;

    initial begin
        vecs[0] = '{we: 1'b1, addr: 24'h000010, wdata: 16'hBEEF, rsp: 16'h0000, exp_cmd: 41'h1_000010_BEEF};
        vecs[1] = '{we: 1'b0, addr: 24'h000010, wdata: 16'h0000, rsp: 16'hBEEF, exp_cmd: 41'h0_000010_0000};
        vecs[2] = '{we: 1'b1, addr: 24'hFFFFFF, wdata: 16'h1234, rsp: 16'h0000, exp_cmd: 41'h1_FFFFFF_1234};
        vecs[3] = '{we: 1'b0, addr: 24'hFFFFFF, wdata: 16'h0000, rsp: 16'h1234, exp_cmd: 41'h0_FFFFFF_0000};
        vecs[4] = '{we: 1'b0, addr: 24'h000000, wdata: 16'h5555, rsp: 16'h0000, exp_cmd: 41'h0_000000_0000};
        vecs[5] = '{we: 1'b1, addr: 24'h000000, wdata: 16'h0000, rsp: 16'h0000, exp_cmd: 41'h1_000000_0000};
        vecs[6] = '{we: 1'b0, addr: 24'hABCDEF, wdata: 16'hFFFF, rsp: 16'hA5A5, exp_cmd: 41'h0_ABCDEF_0000};

        // Reset state.
        #12;
        check("reset host_ready_o", host_ready_o, 0);
        check("reset host_rvalid_o", host_rvalid_o, 0);
        check("reset host_rdata_o", host_rdata_o, 0);
        check("reset cmd_d_o", cmd_d_o, 0);
        check("reset cmd_enq_o", cmd_enq_o, 0);
        check("reset rsp_deq_o", rsp_deq_o, 0);
        check("reset busy_o", busy_o, 0);
        check("reset error_o", error_o, 0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        #1;
        check("idle host_ready_o", host_ready_o, 1);
        cycle(1);

        // Table-driven single transactions.
        for (int i = 0; i < 7; i++) begin
            r0 = rx_cnt; d0 = deq_cnt;
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, ok);
            check($sformatf("vec%0d accepted", i), ok, 1);
            @(negedge clk);
            check($sformatf("vec%0d cmd_enq_o", i), cmd_enq_o, 1);
            check($sformatf("vec%0d cmd_d_o", i), cmd_d_o, vecs[i].exp_cmd);
            check($sformatf("vec%0d ready low while enq", i), host_ready_o, 0);
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("vec%0d cmd_enq_o one cycle", i), cmd_enq_o, 0);
            check($sformatf("vec%0d cmd_d_o hold", i), cmd_d_o, vecs[i].exp_cmd);
            @(posedge clk); #1;
            if (!vecs[i].we) begin
                inject(vecs[i].rsp);
                wait_rsp($sformatf("vec%0d", i), vecs[i].rsp);
            end else begin
                cycle(4);
                check($sformatf("vec%0d write no rvalid", i), rx_cnt, r0);
                check($sformatf("vec%0d write no deq", i), deq_cnt, d0);
            end
            cycle(1);
            check($sformatf("vec%0d busy_o idle", i), busy_o, 0);
        end

        // Outstanding-read limit: four reads with responses withheld, fifth blocked, writes still pass.
        base = rx_cnt;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 24'h000100 + 24'(i), 16'h0000, ok);
            check($sformatf("limit read%0d accepted", i), ok, 1);
        end
        cycle(2);
        check("limit busy_o", busy_o, 1);
        host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 24'h000104; #1;
        for (int i = 0; i < 5; i++) begin
            check("limit 5th read blocked", host_ready_o, 0);
            @(posedge clk); #2;
        end
        host_we_i = 1'b1; #1;
        check("limit write ready", host_ready_o, 1);
        host_req_i = 1'b0;
        issue(1'b1, 24'h000200, 16'hCAFE, ok);
        check("limit write accepted", ok, 1);
        @(negedge clk);
        check("limit write cmd_d_o", cmd_d_o, 41'h1_000200_CAFE);
        @(posedge clk); #1;
        inject(16'h1001);
        issue(1'b0, 24'h000104, 16'h0000, ok);
        check("limit 5th read after release", ok, 1);
        for (int i = 1; i < 5; i++) inject(16'h1001 + 16'(i));
        n = 0;
        while (rx_cnt < base + 5 && n < 200) begin
            cycle(1);
            n++;
        end
        check("limit response count", rx_cnt, base + 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("limit rdata order %0d", i), rx_mem[base + i], 16'h1001 + 16'(i));
        check("deq never back-to-back", b2b_cnt, 0);

        // Writer FIFO full for 20 cycles with a pending write.
        cycle(3);
        e0 = enq_cnt; rdy_hi = 0;
        cmd_full_i = 1'b1;
        host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 24'h000333; host_wdata_i = 16'h4444;
        repeat (20) begin
            @(negedge clk);
            if (host_ready_o) rdy_hi++;
        end
        @(posedge clk); #1;
        check("full ready low cycles", rdy_hi, 0);
        check("full no enq", enq_cnt, e0);
        cmd_full_i = 1'b0; #1;
        check("full released ready", host_ready_o, 1);
        @(posedge clk); #1;
        host_req_i = 1'b0;
        check("full released enq", cmd_enq_o, 1);
        check("full released cmd_d_o", cmd_d_o, 41'h1_000333_4444);

        // Unrequested response must stay in the FIFO.
        cycle(3);
        check("stray busy_o idle", busy_o, 0);
        d0 = deq_cnt; r0 = rx_cnt;
        inject(16'hDEAD);
        cycle(10);
        check("stray no deq", deq_cnt, d0);
        check("stray no rvalid", rx_cnt, r0);
        reset_i = 1'b1;
        cycle(1);
        reset_i = 1'b0;
        cycle(1);

        // Watchdog: read with no response.
        issue(1'b0, 24'h000555, 16'h0000, ok);
        check("wd read accepted", ok, 1);
        cycle(10);
        check("wd error before limit", error_o, 0);
        cycle(10);
        check("wd error at limit", error_o, EXP_ERR);
        r0 = rx_cnt;
        inject(16'h7777);
        n = 0;
        while (rx_cnt == r0 && n < 50) begin
            cycle(1);
            n++;
        end
        check("wd late response count", rx_cnt, r0 + 1);
        check("wd late response data", rx_mem[r0], 16'h7777);
        check("wd error sticky", error_o, EXP_ERR);

        // Asynchronous reset in the middle of a pending read.
        cycle(3);
        issue(1'b0, 24'h000666, 16'h0000, ok);
        cycle(3);
        check("mid reset busy before", busy_o, 1);
        @(negedge clk); #1;
        reset_i = 1'b1; #1;
        check("async reset busy_o", busy_o, 0);
        check("async reset error_o", error_o, 0);
        check("async reset cmd_d_o", cmd_d_o, 0);
        check("async reset host_ready_o", host_ready_o, 0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        cycle(1);
        d0 = deq_cnt;
        inject(16'h8888);
        cycle(8);
        check("reset cleared inflight", deq_cnt, d0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
